// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store, holds the pipe
// until the memory acknowledges, and registers the MEM/WB results for write-back.
module mem_stage #(
  parameter int Size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [Size-1:0] ALU_Result,
  input  logic [Size-1:0] Store_Data,
  input  logic [Size-1:0] PC_4_in,
  input  logic            Mem_read,
  input  logic            Mem_write,
  input  logic [2:0]      Funct3,
  input  logic [4:0]      Rd_in,
  input  logic            Reg_write_in,
  input  logic [1:0]      Data_wb_control_in,
  input  logic            flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [Size-1:0] dmem_addr,
  output logic [Size-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic [Size-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            stall,
  output logic            out_valid,
  output logic [Size-1:0] ALU_Data,
  output logic [Size-1:0] Mem_Data,
  output logic [Size-1:0] PC_4,
  output logic [1:0]      Data_wb_control,
  output logic [4:0]      Rd_out,
  output logic            Reg_write_out,
  output logic            misaligned
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  function automatic logic bad_access(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: bad_access = 1'b0;
      3'b001, 3'b101: bad_access = off[0];
      3'b010:         bad_access = |off;
      default:        bad_access = 1'b1;
    endcase
  endfunction

  function automatic logic [Size-1:0] store_lanes(input logic [Size-1:0] sd, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   store_lanes = Size'({4{sd[7:0]}});
      2'b01:   store_lanes = Size'({2{sd[15:0]}});
      default: store_lanes = sd;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'(4'b0001 << off);
      2'b01:   store_be = 4'(4'b0011 << off);
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [Size-1:0] load_extract(input logic [Size-1:0] word,
                                                   input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] w32;
    logic [7:0]  b;
    logic [15:0] h;
    w32 = word[31:0];
    b   = 8'(w32 >> {off, 3'b000});
    h   = 16'(w32 >> {off[1], 4'b0000});
    case (f3)
      3'b000:  load_extract = {{(Size-8){b[7]}}, b};
      3'b001:  load_extract = {{(Size-16){h[15]}}, h};
      3'b100:  load_extract = {{(Size-8){1'b0}}, b};
      3'b101:  load_extract = {{(Size-16){1'b0}}, h};
      default: load_extract = word;
    endcase
  endfunction

  logic [0:0]      state_q, state_d;
  logic            drop_q, drop_d;
  logic            we_q, we_d, ld_q, ld_d, regw_q, regw_d;
  logic [3:0]      be_q, be_d;
  logic [Size-1:0] addr_q, addr_d, wdata_q, wdata_d, pc4_q, pc4_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic [1:0]      wbc_q, wbc_d;

  logic            ov_q, ov_d, rw_out_q, rw_out_d, mis_out_q, mis_out_d;
  logic [Size-1:0] alu_out_q, alu_out_d, mem_out_q, mem_out_d, pc4_out_q, pc4_out_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic [1:0]      wbc_out_q, wbc_out_d;

  logic mem_op, mis, accept, start, in_wait, kill;

  assign mem_op  = Mem_read | Mem_write;
  assign mis     = mem_op & bad_access(Funct3, ALU_Result[1:0]);
  assign accept  = (state_q == IDLE) & in_valid & ~flush;
  assign start   = accept & mem_op & ~mis;
  assign in_wait = (state_q == WAIT);
  assign kill    = drop_q | flush;

  assign stall      = start | (in_wait & ~dmem_ack);
  assign dmem_req   = in_wait;
  assign dmem_we    = in_wait & we_q;
  assign dmem_be    = in_wait ? be_q : 4'b0000;
  assign dmem_addr  = {addr_q[Size-1:2], 2'b00};
  assign dmem_wdata = wdata_q;

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    we_d      = we_q;
    ld_d      = ld_q;
    regw_d    = regw_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pc4_d     = pc4_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    wbc_d     = wbc_q;
    ov_d      = 1'b0;
    rw_out_d  = 1'b0;
    mis_out_d = 1'b0;
    alu_out_d = alu_out_q;
    mem_out_d = mem_out_q;
    pc4_out_d = pc4_out_q;
    rd_out_d  = rd_out_q;
    wbc_out_d = wbc_out_q;
    if (state_q == IDLE) begin
      drop_d = 1'b0;
      if (start) begin
        state_d = WAIT;
        we_d    = Mem_write;
        ld_d    = Mem_read;
        regw_d  = Reg_write_in;
        be_d    = store_be(Funct3, ALU_Result[1:0]);
        addr_d  = ALU_Result;
        wdata_d = store_lanes(Store_Data, Funct3);
        pc4_d   = PC_4_in;
        f3_d    = Funct3;
        rd_d    = Rd_in;
        wbc_d   = Data_wb_control_in;
      end else if (accept) begin
        // Non-memory and misaligned instructions pass straight to MEM/WB.
        ov_d      = 1'b1;
        rw_out_d  = Reg_write_in & ~mis;
        mis_out_d = mis;
        alu_out_d = ALU_Result;
        mem_out_d = '0;
        pc4_out_d = PC_4_in;
        rd_out_d  = Rd_in;
        wbc_out_d = Data_wb_control_in;
      end
    end else begin
      if (flush) drop_d = 1'b1;
      if (dmem_ack) begin
        // A flushed transaction still completes on the bus but retires as a bubble.
        state_d   = IDLE;
        drop_d    = 1'b0;
        ov_d      = ~kill;
        rw_out_d  = regw_q & ~kill;
        alu_out_d = addr_q;
        mem_out_d = ld_q ? load_extract(dmem_rdata, addr_q[1:0], f3_q) : '0;
        pc4_out_d = pc4_q;
        rd_out_d  = rd_q;
        wbc_out_d = wbc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      drop_q    <= 1'b0;
      we_q      <= 1'b0;
      ld_q      <= 1'b0;
      regw_q    <= 1'b0;
      be_q      <= 4'b0000;
      ov_q      <= 1'b0;
      rw_out_q  <= 1'b0;
      mis_out_q <= 1'b0;
      alu_out_q <= '0;
      mem_out_q <= '0;
      pc4_out_q <= '0;
      rd_out_q  <= '0;
      wbc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      we_q      <= we_d;
      ld_q      <= ld_d;
      regw_q    <= regw_d;
      be_q      <= be_d;
      ov_q      <= ov_d;
      rw_out_q  <= rw_out_d;
      mis_out_q <= mis_out_d;
      alu_out_q <= alu_out_d;
      mem_out_q <= mem_out_d;
      pc4_out_q <= pc4_out_d;
      rd_out_q  <= rd_out_d;
      wbc_out_q <= wbc_out_d;
    end
  end

  // Transaction payload: only meaningful while in WAIT, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    pc4_q   <= pc4_d;
    f3_q    <= f3_d;
    rd_q    <= rd_d;
    wbc_q   <= wbc_d;
  end

  assign out_valid       = ov_q;
  assign ALU_Data        = alu_out_q;
  assign Mem_Data        = mem_out_q;
  assign PC_4            = pc4_out_q;
  assign Data_wb_control = wbc_out_q;
  assign Rd_out          = rd_out_q;
  assign Reg_write_out   = rw_out_q;
  assign misaligned      = mis_out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random loads/stores against a behavioural model
// of access size, alignment, lane selection and write-back outcome.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] ALU_Result, Store_Data, PC_4_in;
  logic        Mem_read, Mem_write;
  logic [2:0]  Funct3;
  logic [4:0]  Rd_in;
  logic        Reg_write_in;
  logic [1:0]  Data_wb_control_in;
  logic        flush;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall, out_valid;
  logic [31:0] ALU_Data, Mem_Data, PC_4;
  logic [1:0]  Data_wb_control;
  logic [4:0]  Rd_out;
  logic        Reg_write_out, misaligned;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.Size(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ALU_Result(ALU_Result),
    .Store_Data(Store_Data), .PC_4_in(PC_4_in), .Mem_read(Mem_read), .Mem_write(Mem_write),
    .Funct3(Funct3), .Rd_in(Rd_in), .Reg_write_in(Reg_write_in),
    .Data_wb_control_in(Data_wb_control_in), .flush(flush), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall), .out_valid(out_valid),
    .ALU_Data(ALU_Data), .Mem_Data(Mem_Data), .PC_4(PC_4), .Data_wb_control(Data_wb_control),
    .Rd_out(Rd_out), .Reg_write_out(Reg_write_out), .misaligned(misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, alignment by modulo, lanes by shifting.
  function automatic int acc_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_mis(input bit memop, input logic [2:0] f3, input logic [31:0] addr);
    if (!memop) return 1'b0;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    return (int'(addr % 4) % acc_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [2:0] f3,
                                           input logic [31:0] addr);
    int n;
    longint v;
    longint w;
    n = acc_bytes(f3);
    if (n == 4) return rdata;
    w = longint'(rdata);
    v = (w >> (8 * int'(addr % 4))) % (longint'(1) << (8 * n));
    if (!f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
    int m;
    m = ((1 << acc_bytes(f3)) - 1) << int'(addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (acc_bytes(f3))
      1:       return (sd & 32'hFF) * 32'h0101_0101;
      2:       return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; ALU_Result = '0; Store_Data = '0; PC_4_in = '0;
    Mem_read = 1'b0; Mem_write = 1'b0; Funct3 = '0; Rd_in = '0; Reg_write_in = 1'b0;
    Data_wb_control_in = '0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  // One instruction through the stage; lat = non-ack WAIT cycles before the ack cycle.
  task automatic run_op(input string tag, input bit rd_i, input bit wr_i, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] pc4,
                        input logic [4:0] rdn, input bit rw, input logic [1:0] wbc,
                        input int lat, input int flush_at, input logic [31:0] rdata);
    bit memop, mis, go, drop;
    int stalls;
    memop = rd_i | wr_i;
    mis = ref_mis(memop, f3, addr);
    go = memop && !mis;
    drop = 1'b0;
    stalls = 0;
    @(negedge clk);
    in_valid = 1'b1; ALU_Result = addr; Store_Data = sd; PC_4_in = pc4;
    Mem_read = rd_i; Mem_write = wr_i; Funct3 = f3; Rd_in = rdn; Reg_write_in = rw;
    Data_wb_control_in = wbc; flush = 1'b0; dmem_ack = 1'b0;
    #1;
    chk1({tag, ".stall_issue"}, stall, go);
    chk1({tag, ".req_idle"}, dmem_req, 1'b0);
    if (stall) stalls++;
    @(posedge clk); #1;
    if (go) begin
      chk1({tag, ".bubble"}, out_valid, 1'b0);
      for (int i = 0; i <= lat; i++) begin
        @(negedge clk);
        in_valid = $urandom_range(1, 0); ALU_Result = $urandom; Store_Data = $urandom;
        PC_4_in = $urandom; Mem_read = $urandom_range(1, 0); Mem_write = 1'b0;
        Funct3 = 3'($urandom); Rd_in = 5'($urandom); Reg_write_in = 1'b1;
        dmem_ack = (i == lat);
        dmem_rdata = (i == lat) ? rdata : $urandom;
        flush = (i == flush_at);
        if (flush) drop = 1'b1;
        #1;
        chk1({tag, ".req"}, dmem_req, 1'b1);
        chk({tag, ".addr"}, dmem_addr, addr & ~32'h3);
        chk1({tag, ".we"}, dmem_we, wr_i);
        if (wr_i) begin
          chk({tag, ".be"}, {28'd0, dmem_be}, {28'd0, ref_be(f3, addr)});
          chk({tag, ".wdata"}, dmem_wdata, ref_wdata(f3, sd));
        end
        chk1({tag, ".stall_wait"}, stall, !dmem_ack);
        if (stall) stalls++;
        @(posedge clk); #1;
      end
      chk({tag, ".stall_cycles"}, 32'(stalls), 32'(1 + lat));
    end
    chk1({tag, ".out_valid"}, out_valid, !drop);
    chk1({tag, ".reg_write"}, Reg_write_out, rw && !drop && !mis);
    if (!drop) begin
      chk1({tag, ".misaligned"}, misaligned, mis);
      chk({tag, ".alu_data"}, ALU_Data, addr);
      chk({tag, ".mem_data"}, Mem_Data, (rd_i && !mis) ? ref_load(rdata, f3, addr) : 32'd0);
      chk({tag, ".pc4"}, PC_4, pc4);
      chk({tag, ".rd"}, {27'd0, Rd_out}, {27'd0, rdn});
      chk({tag, ".wbc"}, {30'd0, Data_wb_control}, {30'd0, wbc});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk1({tag, ".req_released"}, dmem_req, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, ".out_valid"}, out_valid, 1'b0);
    chk1({tag, ".reg_write"}, Reg_write_out, 1'b0);
    chk1({tag, ".misaligned"}, misaligned, 1'b0);
    chk({tag, ".alu_data"}, ALU_Data, 32'd0);
    chk({tag, ".mem_data"}, Mem_Data, 32'd0);
    chk({tag, ".pc4"}, PC_4, 32'd0);
    chk({tag, ".rd"}, {27'd0, Rd_out}, 32'd0);
    chk({tag, ".wbc"}, {30'd0, Data_wb_control}, 32'd0);
    chk1({tag, ".req"}, dmem_req, 1'b0);
    chk1({tag, ".we"}, dmem_we, 1'b0);
    chk({tag, ".be"}, {28'd0, dmem_be}, 32'd0);
    chk1({tag, ".stall"}, stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ld_f3s [6];
    logic [2:0] st_f3s [3];
    ld_f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
    st_f3s = '{3'd0, 3'd1, 3'd2};
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op("alu_op", 0, 0, 3'd0, 32'h1234, 32'd0, 32'h44, 5'd5, 1, 2'b00, 0, -1, 32'd0);
    run_op("lb_sext", 1, 0, 3'd0, 32'h103, 32'd0, 32'h200, 5'd7, 1, 2'b01, 3, -1, 32'h80FF_FFFF);
    chk("lb_sext.const", Mem_Data, 32'hFFFF_FF80);
    run_op("sh_store", 0, 1, 3'd1, 32'h102, 32'hAAAA_BEEF, 32'h204, 5'd0, 0, 2'b00, 2, -1, 32'd0);
    run_op("lw_misal", 1, 0, 3'd2, 32'h101, 32'd0, 32'h208, 5'd9, 1, 2'b01, 0, -1, 32'd0);
    run_op("lhu_flush", 1, 0, 3'd5, 32'h2, 32'd0, 32'h20C, 5'd3, 1, 2'b01, 2, 1, 32'h1234_5678);
    run_op("bad_f3", 1, 0, 3'd3, 32'h40, 32'd0, 32'h210, 5'd4, 1, 2'b01, 0, -1, 32'd0);
    run_op("lh_sext", 1, 0, 3'd1, 32'h22, 32'd0, 32'h214, 5'd6, 1, 2'b01, 0, -1, 32'h9ABC_0000);
    run_op("lw_flush_ack", 1, 0, 3'd2, 32'h30, 32'd0, 32'h218, 5'd8, 1, 2'b01, 1, 1, 32'h5555_AAAA);

    // Flush in IDLE: nothing accepted, bubble written.
    @(negedge clk);
    in_valid = 1'b1; Mem_read = 1'b1; Funct3 = 3'd2; ALU_Result = 32'h100; Reg_write_in = 1'b1;
    flush = 1'b1;
    #1;
    chk1("idle_flush.stall", stall, 1'b0);
    @(posedge clk); #1;
    chk1("idle_flush.req", dmem_req, 1'b0);
    chk1("idle_flush.out_valid", out_valid, 1'b0);
    chk1("idle_flush.reg_write", Reg_write_out, 1'b0);
    @(negedge clk);
    idle_inputs();

    // Reset during WAIT aborts the access; a late ack must not retire anything.
    @(negedge clk);
    in_valid = 1'b1; Mem_read = 1'b1; Funct3 = 3'd2; ALU_Result = 32'h10; Rd_in = 5'd2;
    Reg_write_in = 1'b1; PC_4_in = 32'h300;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk1("rst_wait.req_before", dmem_req, 1'b1);
    @(posedge clk); #1;
    chk_all_zero("rst_wait.after_rst");
    @(negedge clk);
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk1("rst_wait.req_at_ack", dmem_req, 1'b0);
    chk1("rst_wait.stall_at_ack", stall, 1'b0);
    @(posedge clk); #1;
    chk_all_zero("rst_wait.stray_ack");
    @(negedge clk);
    idle_inputs();

    for (int k = 0; k < 40; k++) begin
      int kind, lat, fat;
      logic [2:0] f3;
      kind = $urandom_range(2, 0);
      f3 = (kind == 2) ? st_f3s[$urandom_range(2, 0)] : ld_f3s[$urandom_range(5, 0)];
      lat = $urandom_range(3, 0);
      fat = ($urandom_range(4, 0) == 0) ? $urandom_range(lat, 0) : -1;
      run_op($sformatf("rand%0d", k), kind == 1, kind == 2, f3, $urandom, $urandom, $urandom,
             5'($urandom), 1'($urandom), 2'($urandom), lat, fat, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
